// File: rtl/key_scan_writer.sv
// key_scan_writer
//   Scans a 4x4 active-low key matrix, debounces each press, encodes the key
//   as an ASCII hex character ('0'..'9', 'A'..'F') and writes exactly one byte
//   per press into a FIFO. The FIFO full flag holds the write off.
//
// Handshake: wrsig is a one-cycle write strobe with dataout valid in the same
//   cycle. A write is only issued on a cycle where fifo_full was sampled low on
//   the preceding edge. There is no ready/ack; the FIFO must accept any strobe
//   issued while it reported not-full.
//
// Ports:
//   clk_50MHz  in   sole clock, rising edge
//   rst        in   synchronous active-high reset
//   key_row    in   [3:0] matrix rows, asynchronous, low = closed key
//   key_col    out  [3:0] column drive, exactly one bit low
//   fifo_full  in   FIFO full, writes held off while high
//   wrsig      out  one-cycle FIFO write strobe
//   dataout    out  [7:0] byte written, held until the next write
//
// The FSM state is held in state_q for observation by checkers.
module key_scan_writer #(
  parameter int CLK_DIV        = 50000,
  parameter int DEBOUNCE_TICKS = 20
) (
  input  logic       clk_50MHz,
  input  logic       rst,
  input  logic [3:0] key_row,
  output logic [3:0] key_col,
  input  logic       fifo_full,
  output logic       wrsig,
  output logic [7:0] dataout
);

  localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int DEB_W = $clog2(DEBOUNCE_TICKS + 1);
  localparam logic [CNT_W-1:0] TICK_LAST = CNT_W'(CLK_DIV - 1);
  localparam logic [DEB_W-1:0] DEB_DONE  = DEB_W'(DEBOUNCE_TICKS);
  localparam logic [DEB_W-1:0] DEB_ONE   = DEB_W'(1);

  typedef enum logic [1:0] {
    SCAN     = 2'd0,
    DEBOUNCE = 2'd1,
    EMIT     = 2'd2,
    RELEASE  = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [3:0]       row_s1_q, row_s2_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [DEB_W-1:0] deb_q, deb_d;
  logic [3:0]       col_q, col_d;
  logic [1:0]       row_idx_q, row_idx_d;
  logic [1:0]       col_idx_q, col_idx_d;
  logic             wrsig_q, wrsig_d;
  logic [7:0]       data_q, data_d;

  logic       tick;
  logic       any_low;
  logic [1:0] low_row;
  logic [1:0] cur_col_idx;
  logic [3:0] col_rot;
  logic       latched_row_high;

  // ASCII hex of idx = 4*r + c.
  function automatic logic [7:0] encode(input logic [1:0] r, input logic [1:0] c);
    logic [7:0] idx;
    idx = {4'h0, r, c};
    if (idx < 8'd10) return 8'h30 + idx;
    else             return 8'h41 + (idx - 8'd10);
  endfunction

  assign tick    = (cnt_q == TICK_LAST);
  assign any_low = (row_s2_q != 4'hF);
  assign col_rot = {col_q[2:0], col_q[3]};
  assign latched_row_high = row_s2_q[row_idx_q];

  // Lowest-index low row wins when several are closed.
  always_comb begin
    low_row = 2'd0;
    if      (!row_s2_q[0]) low_row = 2'd0;
    else if (!row_s2_q[1]) low_row = 2'd1;
    else if (!row_s2_q[2]) low_row = 2'd2;
    else if (!row_s2_q[3]) low_row = 2'd3;
  end

  always_comb begin
    cur_col_idx = 2'd0;
    case (col_q)
      4'b1110: cur_col_idx = 2'd0;
      4'b1101: cur_col_idx = 2'd1;
      4'b1011: cur_col_idx = 2'd2;
      4'b0111: cur_col_idx = 2'd3;
      default: cur_col_idx = 2'd0;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = tick ? '0 : cnt_q + CNT_W'(1);
    deb_d     = deb_q;
    col_d     = col_q;
    row_idx_d = row_idx_q;
    col_idx_d = col_idx_q;
    wrsig_d   = 1'b0;
    data_d    = data_q;

    case (state_q)
      SCAN: begin
        if (tick) begin
          if (any_low) begin
            row_idx_d = low_row;
            col_idx_d = cur_col_idx;
            deb_d     = DEB_ONE;
            state_d   = DEBOUNCE;
          end else begin
            col_d = col_rot;
          end
        end
      end
      DEBOUNCE: begin
        if (tick) begin
          if (!latched_row_high) begin
            deb_d = deb_q + DEB_ONE;
            if (deb_q + DEB_ONE == DEB_DONE) state_d = EMIT;
          end else begin
            deb_d   = '0;
            col_d   = col_rot;
            state_d = SCAN;
          end
        end
      end
      EMIT: begin
        // Not tick-gated: the write goes out on the first not-full edge.
        if (!fifo_full) begin
          wrsig_d = 1'b1;
          data_d  = encode(row_idx_q, col_idx_q);
          deb_d   = '0;
          state_d = RELEASE;
        end
      end
      RELEASE: begin
        if (tick) begin
          if (latched_row_high) begin
            deb_d = deb_q + DEB_ONE;
            if (deb_q + DEB_ONE == DEB_DONE) begin
              deb_d   = '0;
              col_d   = col_rot;
              state_d = SCAN;
            end
          end else begin
            deb_d = '0;
          end
        end
      end
      default: state_d = SCAN;
    endcase
  end

  always_ff @(posedge clk_50MHz) begin
    if (rst) begin
      state_q   <= SCAN;
      row_s1_q  <= 4'hF;
      row_s2_q  <= 4'hF;
      cnt_q     <= '0;
      deb_q     <= '0;
      col_q     <= 4'b1110;
      row_idx_q <= 2'd0;
      col_idx_q <= 2'd0;
      wrsig_q   <= 1'b0;
      data_q    <= 8'h00;
    end else begin
      state_q   <= state_d;
      row_s1_q  <= key_row;
      row_s2_q  <= row_s1_q;
      cnt_q     <= cnt_d;
      deb_q     <= deb_d;
      col_q     <= col_d;
      row_idx_q <= row_idx_d;
      col_idx_q <= col_idx_d;
      wrsig_q   <= wrsig_d;
      data_q    <= data_d;
    end
  end

  assign key_col = col_q;
  assign wrsig   = wrsig_q;
  assign dataout = data_q;

endmodule

// File: tb/tb_key_scan_writer.sv
module tb_key_scan_writer;

  localparam int CLK_DIV        = 4;
  localparam int DEBOUNCE_TICKS = 3;

  localparam logic [1:0] S_SCAN     = 2'd0;
  localparam logic [1:0] S_DEBOUNCE = 2'd1;
  localparam logic [1:0] S_EMIT     = 2'd2;

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] key_row;
  logic [3:0] key_col;
  logic       fifo_full = 1'b0;
  logic       wrsig;
  logic [7:0] dataout;

  always #5 clk = ~clk;

  key_scan_writer #(
    .CLK_DIV(CLK_DIV),
    .DEBOUNCE_TICKS(DEBOUNCE_TICKS)
  ) dut (
    .clk_50MHz(clk),
    .rst(rst),
    .key_row(key_row),
    .key_col(key_col),
    .fifo_full(fifo_full),
    .wrsig(wrsig),
    .dataout(dataout)
  );

  logic [1:0] dut_state;
  assign dut_state = dut.state_q;

  // Key matrix model: one closed key pulls its row low while its column is driven.
  logic       key_pressed = 1'b0;
  logic [1:0] key_r = 2'd0;
  logic [1:0] key_c = 2'd0;
  assign key_row = (key_pressed && !key_col[key_c]) ? ~(4'b0001 << key_r) : 4'hF;

  int checks = 0;
  int errors = 0;
  int wr_count = 0;
  logic prev_wr = 1'b0;
  logic [7:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------- scoreboard ----------------
  always @(negedge clk) begin
    if (wrsig) begin
      wr_count++;
      check("no_back_to_back_strobe", {31'd0, prev_wr}, 32'd0);
      if (exp_q.size() == 0) begin
        check("unexpected_write", {24'd0, dataout}, 32'hFFFF_FFFF);
      end else begin
        check("write_data", {24'd0, dataout}, {24'd0, exp_q.pop_front()});
      end
    end
    prev_wr = wrsig;
  end

  // ---------------- driver tasks ----------------
  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press(input logic [1:0] r, input logic [1:0] c);
    key_r = r;
    key_c = c;
    key_pressed = 1'b1;
  endtask

  task automatic release_key();
    key_pressed = 1'b0;
  endtask

  // Bounded wait for a state; the final comparison fails if the budget expires.
  task automatic wait_state(input string tag, input logic [1:0] s, input int budget);
    int n;
    n = 0;
    while (dut_state !== s && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(tag, {30'd0, dut_state}, {30'd0, s});
  endtask

  int base;

  // ---------------- directed sequence ----------------
  initial begin
    // Reset
    rst = 1'b1;
    cycles(3);
    check("reset_key_col", {28'd0, key_col}, 32'hE);
    check("reset_wrsig", {31'd0, wrsig}, 32'd0);
    check("reset_dataout", {24'd0, dataout}, 32'h00);
    check("reset_state", {30'd0, dut_state}, {30'd0, S_SCAN});
    rst = 1'b0;
    cycles(4);
    check("rotate_1", {28'd0, key_col}, 32'hD);
    cycles(4);
    check("rotate_2", {28'd0, key_col}, 32'hB);
    cycles(4);
    check("rotate_3", {28'd0, key_col}, 32'h7);
    cycles(4);
    check("rotate_4", {28'd0, key_col}, 32'hE);

    // Single press: row 1 / column 2 -> idx 6 -> '6'
    base = wr_count;
    exp_q.push_back(8'h36);
    press(2'd1, 2'd2);
    cycles(200);
    check("single_press_count", wr_count - base, 32'd1);
    check("single_press_hold_data", {24'd0, dataout}, 32'h36);
    release_key();
    wait_state("single_press_resume_scan", S_SCAN, 60);
    cycles(8);
    check("single_press_still_one", wr_count - base, 32'd1);

    // Encoding extremes
    base = wr_count;
    exp_q.push_back(8'h30);
    exp_q.push_back(8'h46);
    press(2'd0, 2'd0);
    cycles(100);
    check("extreme_first_data", {24'd0, dataout}, 32'h30);
    release_key();
    cycles(60);
    press(2'd3, 2'd3);
    cycles(100);
    release_key();
    cycles(60);
    check("extreme_count", wr_count - base, 32'd2);
    check("extreme_last_data", {24'd0, dataout}, 32'h46);

    // Bounce rejection: row 2 / column 1 closed for a single tick
    base = wr_count;
    press(2'd2, 2'd1);
    wait_state("bounce_enter_debounce", S_DEBOUNCE, 40);
    release_key();
    check("bounce_col_held", {28'd0, key_col}, 32'hD);
    cycles(6);
    check("bounce_back_to_scan", {30'd0, dut_state}, {30'd0, S_SCAN});
    check("bounce_col_advanced", {28'd0, key_col}, 32'hB);
    cycles(20);
    check("bounce_no_write", wr_count - base, 32'd0);

    // Back-pressure: row 2 / column 0 -> idx 8 -> '8'
    base = wr_count;
    fifo_full = 1'b1;
    press(2'd2, 2'd0);
    wait_state("bp_enter_emit", S_EMIT, 60);
    cycles(40);
    check("bp_no_write_while_full", wr_count - base, 32'd0);
    check("bp_still_emit", {30'd0, dut_state}, {30'd0, S_EMIT});
    exp_q.push_back(8'h38);
    fifo_full = 1'b0;
    cycles(1);
    check("bp_strobe", {31'd0, wrsig}, 32'd1);
    check("bp_data", {24'd0, dataout}, 32'h38);
    cycles(1);
    check("bp_strobe_one_cycle", {31'd0, wrsig}, 32'd0);
    release_key();
    cycles(60);
    check("bp_count", wr_count - base, 32'd1);

    // Reset mid-operation: row 3 / column 0 -> idx 12 -> 'C'
    base = wr_count;
    fifo_full = 1'b1;
    press(2'd3, 2'd0);
    wait_state("rst_mid_enter_emit", S_EMIT, 60);
    rst = 1'b1;
    cycles(1);
    check("rst_mid_wrsig", {31'd0, wrsig}, 32'd0);
    check("rst_mid_key_col", {28'd0, key_col}, 32'hE);
    check("rst_mid_dataout", {24'd0, dataout}, 32'h00);
    check("rst_mid_state", {30'd0, dut_state}, {30'd0, S_SCAN});
    rst = 1'b0;
    fifo_full = 1'b0;
    exp_q.push_back(8'h43);
    cycles(100);
    check("rst_mid_reemit_count", wr_count - base, 32'd1);
    check("rst_mid_reemit_data", {24'd0, dataout}, 32'h43);
    release_key();
    cycles(60);

    check("scoreboard_drained", exp_q.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
